itcm_loader: RTL and testbench
==============================

# itcm_loader

Boot-time instruction loader for riftCore. Accepts a byte stream and packs it little-endian into 32-bit words, four bytes per word. Writes those words into the ITCM that feeds the front end's PC generator, and holds the core in reset until the image is complete. It replaces backdoor ITCM preloading with a synthesizable path, and sits between the platform byte source (UART or debug link) and the ITCM write port / core reset.

## Interface
Parameters:
- AW, 10, ITCM word-address width; depth is 2**AW words.
- TIMEOUT, 1024, max idle cycles between bytes in FILL before error.
- REL_DLY, 4, cycles between load completion and core reset release.

Ports:
- Clocking and reset. One clock; reset is asynchronous and active-low.
  - CLK  in  1  clock.
  - RSTn  in  1  asynchronous active-low reset.
- Load control.
  - load_start  in  1  single-cycle request to begin a load; honoured only in IDLE or ERR.
  - load_len  in  AW+1  number of words to load, sampled with load_start.
- Byte stream.
  - byte_valid  in  1  byte stream valid.
  - byte_data  in  8  byte payload.
  - byte_ready  out  1  loader accepts byte; a transfer occurs when byte_valid && byte_ready.
- ITCM write port.
  - itcm_wen  out  1  ITCM word write strobe, one cycle per word.
  - itcm_addr  out  AW  ITCM word address.
  - itcm_wdata  out  32  packed word.
- Core and status.
  - core_RSTn  out  1  active-low reset to riftCore; low while loading.
  - load_done  out  1  level; image written and core released.
  - load_err  out  1  level; bad length or byte timeout.

## Operation
- States: IDLE, FILL, WRITE, HOLD, RUN, ERR.
- IDLE:
  - core_RSTn=0, byte_ready=0.
  - load_start with load_len in 1..2**AW → FILL; word counter=0, byte index=0.
  - load_len=0 → HOLD directly; the core runs whatever ITCM already contains.
  - load_len>2**AW → ERR.
- FILL:
  - byte_ready=1.
  - Each transfer stores byte_data into bits [8k+7:8k] of the word buffer, where k is the byte index 0..3.
  - The transfer with k=3 → WRITE.
  - Idle counter resets on every transfer. When it reaches TIMEOUT → ERR; the partial word is discarded.
- WRITE:
  - One cycle with itcm_wen=1, itcm_addr=word counter, itcm_wdata=buffer, byte_ready=0.
  - Word counter increments.
  - If the count now equals load_len → HOLD, else → FILL.
- HOLD:
  - Counts REL_DLY cycles → RUN.
- RUN:
  - core_RSTn=1, load_done=1.
  - Terminal state; load_start is ignored. Only RSTn returns the block to IDLE.
- ERR:
  - load_err=1, core_RSTn=0.
  - load_start → IDLE-equivalent restart: load_err cleared, length re-sampled.
- load_start in FILL, WRITE or HOLD is ignored.
- itcm_addr never wraps. The length check bounds the word counter to 2**AW−1.
- itcm_addr and itcm_wdata hold their last values when itcm_wen=0.

## Timing
- Reset values: byte_ready=0, itcm_wen=0, itcm_addr=0, itcm_wdata=0, core_RSTn=0, load_done=0, load_err=0. State=IDLE, all counters 0.
- Reset asserted mid-load:
  - Immediate asynchronous return to the reset values.
  - core_RSTn drops asynchronously.
  - The buffered partial word is lost and no ITCM write occurs.
- load_start sampled at cycle t → byte_ready=1 from t+1.
- Fourth byte transfer at cycle t → itcm_wen=1 during t+1, with byte_ready=0 that cycle.
- Byte_ready returns at t+2.
- Sustained throughput: 4 bytes per 5 cycles.
- Last WRITE at cycle t → core_RSTn and load_done rise at t+1+REL_DLY.
- All outputs are registered; no combinational path from inputs to outputs.
- A timeout error is flagged on the cycle after the idle counter reaches TIMEOUT.

## Structure
- State encoding and the byte-index width live in the shared define.vh alongside the existing core defines:
  - ITCM_LOAD_IDLE … ITCM_LOAD_ERR.
  - Default AW=10, matching the ITCM depth of 2**10 words.
- One sub-module is natural: `gen_dffr`-style reset register cells for the state/counter flops.
  - The packing/FSM logic stays in itcm_loader.
- riftCore's top level gains a variant that routes core_RSTn to the core and itcm_* to the ITCM write port.

## Test plan
- Basic load:
  - Stimulus: load_len=2; bytes 13,00,00,00,6F,00,00,00 streamed back-to-back.
  - Response: writes addr 0 = 0x00000013 and addr 1 = 0x0000006F.
  - Response: byte_ready low exactly in each WRITE cycle; core_RSTn rises 1+REL_DLY cycles after the second write.
- Gapped stream:
  - Stimulus: byte_valid toggled randomly, gaps below TIMEOUT, load_len=8.
  - Response: eight correct little-endian words at addrs 0..7 and no error.
- Timeout:
  - Stimulus: load_len=4; stream stops after 6 bytes.
  - Response: exactly one write (addr 0); load_err=1 TIMEOUT+1 cycles after the last byte; core_RSTn stays 0.
  - Then: a new load_start clears load_err and the load succeeds.
- Length bounds:
  - Stimulus: load_len=1025.
  - Response: ERR with no writes.
  - Stimulus: load_len=1024.
  - Response: last write at addr 0x3FF, then RUN.
  - Stimulus: load_len=0.
  - Response: RUN after REL_DLY cycles with no writes.
- Async reset mid-load:
  - Stimulus: RSTn pulsed low between bytes 2 and 3 of word 5.
  - Response: all outputs at reset values immediately; no write for word 5; a subsequent full load writes from addr 0.
- Ignored start:
  - Stimulus: load_start pulsed during FILL and in RUN.
  - Response: no effect on counters, state, or outputs.

Source files
------------

// File: rtl/itcm_loader_pkg.sv
// Shared types and helpers for the boot-time ITCM loader: FSM state encoding,
// byte-index width and the little-endian byte packing function.
package itcm_loader_pkg;

  localparam int unsigned ITCM_LOAD_BIW    = 2;
  localparam int unsigned ITCM_LOAD_AW_DEF = 10;

  typedef enum logic [2:0] {
    ITCM_LOAD_IDLE  = 3'd0,
    ITCM_LOAD_FILL  = 3'd1,
    ITCM_LOAD_WRITE = 3'd2,
    ITCM_LOAD_HOLD  = 3'd3,
    ITCM_LOAD_RUN   = 3'd4,
    ITCM_LOAD_ERR   = 3'd5
  } itcm_load_state_e;

  // Byte k of the stream lands in bits [8k+7:8k] of the word.
  function automatic logic [31:0] pack_byte(input logic [31:0]              word,
                                            input logic [ITCM_LOAD_BIW-1:0] idx,
                                            input logic [7:0]               data);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/itcm_loader_dffr.sv
// Generic asynchronously reset register cell used for all loader state,
// counters and registered outputs; clears to zero on reset.
module itcm_loader_dffr #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State flop with asynchronous clear
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/itcm_loader.sv
// Boot loader: packs a byte stream into 32-bit little-endian words, writes them
// to the ITCM and holds the core in reset until the image is complete.
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int unsigned AW      = ITCM_LOAD_AW_DEF,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned REL_DLY = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          itcm_wen,
  output logic [AW-1:0] itcm_addr,
  output logic [31:0]   itcm_wdata,
  output logic          core_RSTn,
  output logic          load_done,
  output logic          load_err
);

  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned HW = (REL_DLY > 1) ? $clog2(REL_DLY) : 1;
  localparam int unsigned OW = AW + 37;
  localparam logic [AW:0]   DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REL_DLY - 1);
  localparam logic [ITCM_LOAD_BIW-1:0] IDX_LAST = {ITCM_LOAD_BIW{1'b1}};

  itcm_load_state_e           state_r, state_d;
  logic [2:0]                 state_bits_r;
  logic [AW:0]                cnt_r, cnt_d;
  logic [AW:0]                len_r, len_d;
  logic [ITCM_LOAD_BIW-1:0]   idx_r, idx_d;
  logic [IW-1:0]              idle_r, idle_d;
  logic [HW-1:0]              hold_r, hold_d;
  logic [31:0]                buf_r, buf_d;
  logic [OW-1:0]              out_r, out_d;
  logic                       xfer_s;
  logic                       ready_d, wen_d, rstn_d, done_d, err_d;
  logic [AW-1:0]              addr_d;
  logic [31:0]                wdata_d;

  itcm_loader_dffr #(.W(3))             u_state (.CLK(CLK), .RSTn(RSTn), .d(state_d), .q(state_bits_r));
  itcm_loader_dffr #(.W(AW + 1))        u_cnt   (.CLK(CLK), .RSTn(RSTn), .d(cnt_d),   .q(cnt_r));
  itcm_loader_dffr #(.W(AW + 1))        u_len   (.CLK(CLK), .RSTn(RSTn), .d(len_d),   .q(len_r));
  itcm_loader_dffr #(.W(ITCM_LOAD_BIW)) u_idx   (.CLK(CLK), .RSTn(RSTn), .d(idx_d),   .q(idx_r));
  itcm_loader_dffr #(.W(IW))            u_idle  (.CLK(CLK), .RSTn(RSTn), .d(idle_d),  .q(idle_r));
  itcm_loader_dffr #(.W(HW))            u_hold  (.CLK(CLK), .RSTn(RSTn), .d(hold_d),  .q(hold_r));
  itcm_loader_dffr #(.W(32))            u_buf   (.CLK(CLK), .RSTn(RSTn), .d(buf_d),   .q(buf_r));
  itcm_loader_dffr #(.W(OW))            u_out   (.CLK(CLK), .RSTn(RSTn), .d(out_d),   .q(out_r));

  assign state_r = itcm_load_state_e'(state_bits_r);
  assign {byte_ready, itcm_wen, itcm_addr, itcm_wdata, core_RSTn, load_done, load_err} = out_r;
  // byte_ready is only ever high in FILL, so it alone qualifies a transfer.
  assign xfer_s = byte_valid && byte_ready;

  // Next-state, counter and packing logic
  always_comb begin
    state_d = state_r;
    cnt_d   = cnt_r;
    len_d   = len_r;
    idx_d   = idx_r;
    idle_d  = idle_r;
    hold_d  = hold_r;
    buf_d   = buf_r;
    addr_d  = itcm_addr;
    wdata_d = itcm_wdata;
    case (state_r)
      ITCM_LOAD_IDLE, ITCM_LOAD_ERR: begin
        if (load_start) begin
          len_d  = load_len;
          cnt_d  = '0;
          idx_d  = '0;
          idle_d = '0;
          hold_d = '0;
          if (load_len == '0) begin
            state_d = ITCM_LOAD_HOLD;
          end else if (load_len > DEPTH) begin
            state_d = ITCM_LOAD_ERR;
          end else begin
            state_d = ITCM_LOAD_FILL;
          end
        end else begin
          state_d = state_r;
        end
      end
      ITCM_LOAD_FILL: begin
        if (xfer_s) begin
          buf_d  = pack_byte(buf_r, idx_r, byte_data);
          idx_d  = idx_r + 1'b1;
          idle_d = '0;
          if (idx_r == IDX_LAST) begin
            state_d = ITCM_LOAD_WRITE;
            addr_d  = cnt_r[AW-1:0];
            wdata_d = buf_d;
          end else begin
            state_d = ITCM_LOAD_FILL;
          end
        end else if (idle_r == IDLE_LAST) begin
          // Partial word is simply abandoned in buf_r.
          state_d = ITCM_LOAD_ERR;
        end else begin
          idle_d = idle_r + 1'b1;
        end
      end
      ITCM_LOAD_WRITE: begin
        cnt_d  = cnt_r + 1'b1;
        idle_d = '0;
        if (cnt_d == len_r) begin
          state_d = ITCM_LOAD_HOLD;
          hold_d  = '0;
        end else begin
          state_d = ITCM_LOAD_FILL;
        end
      end
      ITCM_LOAD_HOLD: begin
        if (hold_r == HOLD_LAST) begin
          state_d = ITCM_LOAD_RUN;
        end else begin
          hold_d = hold_r + 1'b1;
        end
      end
      ITCM_LOAD_RUN: begin
        state_d = ITCM_LOAD_RUN;
      end
      default: begin
        state_d = ITCM_LOAD_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    ready_d = (state_d == ITCM_LOAD_FILL);
    wen_d   = (state_d == ITCM_LOAD_WRITE);
    rstn_d  = (state_d == ITCM_LOAD_RUN);
    done_d  = (state_d == ITCM_LOAD_RUN);
    err_d   = (state_d == ITCM_LOAD_ERR);
    out_d   = {ready_d, wen_d, addr_d, wdata_d, rstn_d, done_d, err_d};
  end

endmodule

// File: tb/tb_itcm_loader.sv
// Directed self-checking bench for itcm_loader: basic, gapped, timeout,
// length-bound, async-reset and ignored-start scenarios.
module tb_itcm_loader;

  localparam int unsigned AW      = 10;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned REL_DLY = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          itcm_wen;
  logic [AW-1:0] itcm_addr;
  logic [31:0]   itcm_wdata;
  logic          core_RSTn;
  logic          load_done;
  logic          load_err;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int n_wr = 0;
  int bad_ready = 0;
  logic [AW-1:0] wr_addr [0:2047];
  logic [31:0]   wr_data [0:2047];
  int            wr_cyc  [0:2047];

  logic [7:0] basic_b [0:7] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};

  itcm_loader #(.AW(AW), .TIMEOUT(TIMEOUT), .REL_DLY(REL_DLY)) dut (
    .CLK(CLK), .RSTn(RSTn), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .itcm_wen(itcm_wen), .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata),
    .core_RSTn(core_RSTn), .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  // Cycle counter
  always @(posedge CLK) cyc <= cyc + 1;

  // Write logger, sampled mid-cycle
  always @(negedge CLK) begin
    if (itcm_wen === 1'b1 && n_wr < 2048) begin
      wr_addr[n_wr] <= itcm_addr;
      wr_data[n_wr] <= itcm_wdata;
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
      if (byte_ready !== 1'b0) bad_ready <= bad_ready + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start(input logic [AW:0] len, output int c0);
    load_len   = len;
    load_start = 1'b1;
    c0         = cyc;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    if (w >= 20) chk("byte_ready_wait", 64'(byte_ready), 64'd1);
    tick(1);
    byte_valid = 1'b0;
  endtask

  // which: 0 core_RSTn, 1 load_done, 2 load_err
  task automatic wait_high(input int which, input int limit);
    int w;
    logic s;
    w = 0;
    s = 1'b0;
    while (w < limit) begin
      case (which)
        0:       s = core_RSTn;
        1:       s = load_done;
        default: s = load_err;
      endcase
      if (s === 1'b1) break;
      tick(1);
      w++;
    end
  endtask

  task automatic do_reset();
    load_start = 1'b0;
    byte_valid = 1'b0;
    RSTn = 1'b0;
    tick(2);
    RSTn = 1'b1;
    tick(1);
  endtask

  initial begin
    int c0, base, tr, tl, te;
    logic [31:0] expw;
    RSTn = 1'b0;
    load_start = 1'b0;
    load_len = '0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    tick(3);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_wen",   64'(itcm_wen),   64'd0);
    chk("rst_addr",  64'(itcm_addr),  64'd0);
    chk("rst_wdata", 64'(itcm_wdata), 64'd0);
    chk("rst_core",  64'(core_RSTn),  64'd0);
    chk("rst_done",  64'(load_done),  64'd0);
    chk("rst_err",   64'(load_err),   64'd0);
    RSTn = 1'b1;
    tick(1);

    // Basic two-word load
    base = n_wr;
    start(11'd2, c0);
    chk("basic_ready_t1", 64'(byte_ready), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(basic_b[i]);
    wait_high(0, 50);
    tr = cyc;
    chk("basic_nwr",   64'(n_wr - base), 64'd2);
    chk("basic_addr0", 64'(wr_addr[base]), 64'd0);
    chk("basic_data0", 64'(wr_data[base]), 64'h13);
    chk("basic_addr1", 64'(wr_addr[base+1]), 64'd1);
    chk("basic_data1", 64'(wr_data[base+1]), 64'h6F);
    chk("basic_tput",  64'(wr_cyc[base+1] - wr_cyc[base]), 64'd5);
    chk("basic_rel",   64'(tr - wr_cyc[base+1]), 64'(1 + REL_DLY));
    chk("basic_done",  64'(load_done), 64'd1);
    chk("basic_ready_in_write", 64'(bad_ready), 64'd0);

    // Start in RUN is ignored
    start(11'd3, c0);
    tick(10);
    chk("run_ign_done",  64'(load_done),  64'd1);
    chk("run_ign_core",  64'(core_RSTn),  64'd1);
    chk("run_ign_ready", 64'(byte_ready), 64'd0);
    chk("run_ign_nwr",   64'(n_wr - base), 64'd2);

    // Gapped stream of eight words, with an ignored start mid-FILL
    do_reset();
    base = n_wr;
    start(11'd8, c0);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        byte_valid = 1'b0;
        tick($urandom_range(0, 3));
        if (i == 3 && j == 1) begin
          start(11'd0, c0);
          chk("fill_ign_ready", 64'(byte_ready), 64'd1);
        end
        send_byte(8'hA0 + 8'(4 * i + j));
      end
    end
    wait_high(1, 50);
    chk("gap_nwr", 64'(n_wr - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) expw[8*j +: 8] = 8'hA0 + 8'(4 * i + j);
      chk("gap_addr", 64'(wr_addr[base+i]), 64'(i));
      chk("gap_data", 64'(wr_data[base+i]), 64'(expw));
    end
    chk("gap_err",  64'(load_err),  64'd0);
    chk("gap_done", 64'(load_done), 64'd1);

    // Timeout after six bytes, then recovery
    do_reset();
    base = n_wr;
    start(11'd4, c0);
    for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i));
    tl = cyc - 1;
    wait_high(2, 1200);
    te = cyc;
    chk("to_lat",   64'(te - tl), 64'(TIMEOUT + 1));
    chk("to_err",   64'(load_err), 64'd1);
    chk("to_nwr",   64'(n_wr - base), 64'd1);
    chk("to_addr",  64'(wr_addr[base]), 64'd0);
    chk("to_data",  64'(wr_data[base]), 64'h24232221);
    chk("to_core",  64'(core_RSTn), 64'd0);
    chk("to_ready", 64'(byte_ready), 64'd0);
    base = n_wr;
    start(11'd1, c0);
    chk("to_err_clr", 64'(load_err), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
    wait_high(1, 50);
    chk("rec_nwr",  64'(n_wr - base), 64'd1);
    chk("rec_data", 64'(wr_data[base]), 64'h34333231);
    chk("rec_done", 64'(load_done), 64'd1);

    // Length bounds: 1025 rejected, 1024 fills the ITCM
    do_reset();
    base = n_wr;
    start(11'd1025, c0);
    tick(3);
    chk("len1025_err", 64'(load_err), 64'd1);
    chk("len1025_nwr", 64'(n_wr - base), 64'd0);
    start(11'd1024, c0);
    for (int n = 0; n < 4096; n++) send_byte(8'(n));
    wait_high(1, 50);
    chk("len1024_nwr",  64'(n_wr - base), 64'd1024);
    chk("len1024_addr", 64'(wr_addr[base+1023]), 64'h3FF);
    chk("len1024_data", 64'(wr_data[base+1023]), 64'hFFFEFDFC);
    chk("len1024_done", 64'(load_done), 64'd1);

    // Zero length goes straight to release
    do_reset();
    base = n_wr;
    start(11'd0, c0);
    wait_high(1, 50);
    chk("len0_lat", 64'(cyc - c0), 64'(1 + REL_DLY));
    chk("len0_nwr", 64'(n_wr - base), 64'd0);

    // Async reset between bytes 2 and 3 of word 5
    do_reset();
    base = n_wr;
    start(11'd8, c0);
    for (int n = 0; n < 23; n++) send_byte(8'h40 + 8'(n));
    RSTn = 1'b0;
    #1;
    chk("arst_ready", 64'(byte_ready), 64'd0);
    chk("arst_wen",   64'(itcm_wen),   64'd0);
    chk("arst_addr",  64'(itcm_addr),  64'd0);
    chk("arst_wdata", 64'(itcm_wdata), 64'd0);
    chk("arst_core",  64'(core_RSTn),  64'd0);
    chk("arst_done",  64'(load_done),  64'd0);
    chk("arst_err",   64'(load_err),   64'd0);
    tick(2);
    RSTn = 1'b1;
    tick(2);
    chk("arst_nwr", 64'(n_wr - base), 64'd5);
    base = n_wr;
    start(11'd2, c0);
    for (int n = 0; n < 8; n++) send_byte(8'h80 + 8'(n));
    wait_high(1, 50);
    chk("post_addr0", 64'(wr_addr[base]), 64'd0);
    chk("post_data0", 64'(wr_data[base]), 64'h83828180);
    chk("post_data1", 64'(wr_data[base+1]), 64'h87868584);
    chk("post_done",  64'(load_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
